fifo_rd_cntrl: RTL and testbench

- Read-side controller for the dual-port FIFO memory.
- Owns the read pointer and drives the memory read address.
- Derives the registered empty flag from a write pointer that is already synchronized and Gray-coded.
- Presents FIFO words to a downstream consumer through a one-entry registered output stage with a valid/ready handshake.

---
 rtl/fifo_rd_cntrl.sv | 74 +++++++
 tb/tb_fifo_rd_cntrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_cntrl.sv
// Read-side FIFO controller: owns the read pointer, drives the memory read
// address, derives a registered empty flag from the synchronized Gray write
// pointer, and feeds a one-entry registered output stage (valid/ready).
module fifo_rd_cntrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADD_WIDTH  = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADD_WIDTH:0]    wptr_sync,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADD_WIDTH-1:0]  raddr,
  output logic [ADD_WIDTH:0]    rptr_gray,
  output logic                  empty,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int unsigned PTR_W = ADD_WIDTH + 1;

  typedef enum logic {IDLE = 1'b0, FULL = 1'b1} state_t;

  state_t           state;
  logic [PTR_W-1:0] rptr_bin;
  logic [PTR_W-1:0] rbin_next;
  logic [PTR_W-1:0] rgray_next;
  logic             fetch_c;

  assign raddr    = rptr_bin[ADD_WIDTH-1:0];
  assign rd_valid = (state == FULL);

  // Fetch decision and next read pointer (binary and Gray).
  always_comb begin
    fetch_c    = 1'b0;
    rbin_next  = rptr_bin;
    rgray_next = '0;
    fetch_c    = !empty && (!rd_valid || rd_ready);
    rbin_next  = rptr_bin + PTR_W'(fetch_c);
    rgray_next = rbin_next ^ (rbin_next >> 1);
  end

  // Pointer, empty flag and output-stage FSM; the memory read is asynchronous,
  // so mem_rdata already holds the word at the current raddr.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      rptr_bin  <= '0;
      rptr_gray <= '0;
      empty     <= 1'b1;
      rd_data   <= '0;
    end else begin
      rptr_bin  <= rbin_next;
      rptr_gray <= rgray_next;
      empty     <= (rgray_next == wptr_sync);
      case (state)
        IDLE: begin
          if (fetch_c) begin
            rd_data <= mem_rdata;
            state   <= FULL;
          end
        end
        FULL: begin
          if (fetch_c) begin
            rd_data <= mem_rdata;
          end else if (rd_ready) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_cntrl.sv
// Self-checking bench for fifo_rd_cntrl: behavioural FIFO memory and write
// pointer, vector table for the basic sequences, scoreboard for data order.
module tb_fifo_rd_cntrl;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 3;

  logic          CLK;
  logic          RST;
  logic [AW:0]   wptr_sync;
  logic [DW-1:0] mem_rdata;
  logic [AW-1:0] raddr;
  logic [AW:0]   rptr_gray;
  logic          empty;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW:0]   wptr_bin;
  logic [DW-1:0] sb [$];
  logic          hold_chk;
  logic [DW-1:0] hold_data;
  int            n_tests;
  int            n_fail;

  typedef struct {
    logic          rst;
    int            wr_n;
    logic [31:0]   wr_words;
    logic          ready;
    logic          e_empty;
    logic          e_valid;
    logic [DW-1:0] e_data;
    logic [AW-1:0] e_raddr;
    logic [AW:0]   e_gray;
  } vec_t;

  vec_t vecs [13];

  fifo_rd_cntrl #(.DATA_WIDTH(DW), .ADD_WIDTH(AW)) dut (
    .CLK(CLK), .RST(RST), .wptr_sync(wptr_sync), .mem_rdata(mem_rdata),
    .raddr(raddr), .rptr_gray(rptr_gray), .empty(empty), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_data(rd_data)
  );

  assign mem_rdata = mem[raddr];
  assign wptr_sync = wptr_bin ^ (wptr_bin >> 1);

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write n words into the model memory and advance the write pointer.
  task automatic wr(input int n, input logic [31:0] words);
    logic [31:0] w;
    w = words;
    for (int i = 0; i < n; i++) begin
      mem[wptr_bin[AW-1:0]] = w[7:0];
      sb.push_back(w[7:0]);
      wptr_bin = wptr_bin + 1'b1;
      w = w >> 8;
    end
  endtask

  // One clock: monitor at negedge (handshake + stability), then settle after posedge.
  task automatic tick();
    @(negedge CLK);
    if (RST) begin
      hold_chk = 1'b0;
    end else begin
      if (hold_chk) begin
        chk("hold_valid", 32'(rd_valid), 32'd1);
        chk("hold_data", 32'(rd_data), 32'(hold_data));
      end
      if (rd_valid && rd_ready) begin
        if (sb.size() == 0) begin
          chk("sb_extra_word", 32'(rd_data), 32'hFFFF_FFFF);
        end else begin
          chk("sb_data", 32'(rd_data), 32'(sb.pop_front()));
        end
      end
      hold_chk  = rd_valid && !rd_ready;
      hold_data = rd_data;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, "_data"}, 32'(rd_data), 32'd0);
    chk({tag, "_raddr"}, 32'(raddr), 32'd0);
    chk({tag, "_gray"}, 32'(rptr_gray), 32'd0);
  endtask

  // Mid-cycle reset pulse: outputs must clear with no clock edge.
  task automatic do_reset();
    #2;
    RST = 1'b1;
    #1;
    chk_reset_vals("rst_async");
    sb.delete();
    wptr_bin = '0;
    hold_chk = 1'b0;
    @(negedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int cyc;
    n_tests   = 0;
    n_fail    = 0;
    hold_chk  = 1'b0;
    hold_data = '0;
    wptr_bin  = '0;
    rd_ready  = 1'b0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    RST = 1'b1;
    #12;
    chk_reset_vals("por");
    RST = 1'b0;
    @(posedge CLK);
    #1;

    //           rst  n  words          rdy  empty valid data   raddr gray
    vecs[0]  = '{1'b0, 1, 32'h0000_00A5, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 4'b0000};
    vecs[1]  = '{1'b0, 0, 32'h0,         1'b1, 1'b1, 1'b1, 8'hA5, 3'd1, 4'b0001};
    vecs[2]  = '{1'b0, 0, 32'h0,         1'b1, 1'b1, 1'b0, 8'hA5, 3'd1, 4'b0001};
    vecs[3]  = '{1'b1, 4, 32'h4433_2211, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 4'b0000};
    vecs[4]  = '{1'b0, 0, 32'h0,         1'b0, 1'b0, 1'b1, 8'h11, 3'd1, 4'b0001};
    vecs[5]  = '{1'b0, 0, 32'h0,         1'b0, 1'b0, 1'b1, 8'h11, 3'd1, 4'b0001};
    vecs[6]  = '{1'b0, 0, 32'h0,         1'b0, 1'b0, 1'b1, 8'h11, 3'd1, 4'b0001};
    vecs[7]  = '{1'b0, 0, 32'h0,         1'b0, 1'b0, 1'b1, 8'h11, 3'd1, 4'b0001};
    vecs[8]  = '{1'b0, 0, 32'h0,         1'b0, 1'b0, 1'b1, 8'h11, 3'd1, 4'b0001};
    vecs[9]  = '{1'b0, 0, 32'h0,         1'b1, 1'b0, 1'b1, 8'h22, 3'd2, 4'b0011};
    vecs[10] = '{1'b0, 0, 32'h0,         1'b1, 1'b0, 1'b1, 8'h33, 3'd3, 4'b0010};
    vecs[11] = '{1'b0, 0, 32'h0,         1'b1, 1'b1, 1'b1, 8'h44, 3'd4, 4'b0110};
    vecs[12] = '{1'b0, 0, 32'h0,         1'b1, 1'b1, 1'b0, 8'h44, 3'd4, 4'b0110};

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].rst) do_reset();
      wr(vecs[i].wr_n, vecs[i].wr_words);
      rd_ready = vecs[i].ready;
      tick();
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].e_empty));
      chk($sformatf("v%0d_valid", i), 32'(rd_valid), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d_data", i), 32'(rd_data), 32'(vecs[i].e_data));
      chk($sformatf("v%0d_raddr", i), 32'(raddr), 32'(vecs[i].e_raddr));
      chk($sformatf("v%0d_gray", i), 32'(rptr_gray), 32'(vecs[i].e_gray));
    end

    // Wrap-around: 8 reads, then 3 more past the pointer MSB toggle.
    rd_ready = 1'b0;
    do_reset();
    wr(4, 32'h8382_8180);
    wr(4, 32'h8786_8584);
    rd_ready = 1'b1;
    tick();
    chk("wrap_empty_fall", 32'(empty), 32'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("wrap_raddr%0d", k), 32'(raddr), 32'((k + 1) % 8));
      chk($sformatf("wrap_empty%0d", k), 32'(empty), 32'(k == 7));
    end
    chk("wrap_gray8", 32'(rptr_gray), 32'b1100);
    wr(3, 32'h0090_8F8E);
    tick();
    chk("wrap_refill_empty", 32'(empty), 32'd0);
    for (int k = 8; k < 11; k++) begin
      tick();
      chk($sformatf("wrap_raddr%0d", k), 32'(raddr), 32'((k + 1) % 8));
      chk($sformatf("wrap_empty%0d", k), 32'(empty), 32'(k == 10));
    end
    chk("wrap_gray11", 32'(rptr_gray), 32'b1110);
    tick();
    chk("wrap_drained", 32'(sb.size()), 32'd0);

    // Random backpressure with 3 words available.
    rd_ready = 1'b0;
    do_reset();
    wr(3, 32'h00C3_C2C1);
    cyc = 0;
    while ((sb.size() != 0 || rd_valid) && cyc < 200) begin
      rd_ready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    chk("rand_timeout", 32'(cyc < 200), 32'd1);
    rd_ready = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    chk("rand_no_extra", 32'(rd_valid), 32'd0);
    chk("rand_empty", 32'(empty), 32'd1);

    // Reset with a word held and 2 still in memory.
    rd_ready = 1'b0;
    do_reset();
    wr(4, 32'hD4D3_D2D1);
    tick();
    tick();
    rd_ready = 1'b1;
    tick();
    chk("mid_valid", 32'(rd_valid), 32'd1);
    chk("mid_data", 32'(rd_data), 32'hD2);
    rd_ready = 1'b0;
    do_reset();
    chk_reset_vals("post_rst");
    for (int k = 0; k < 3; k++) tick();
    chk("post_rst_empty", 32'(empty), 32'd1);
    chk("post_rst_valid", 32'(rd_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
